cv32e40s_uop_sequencer: RTL and testbench
=========================================

CV32E40S_UOP_SEQUENCER -- requirements
Module: cv32e40s_uop_sequencer

Interface
REQ-001 Parameter MAX_REGS, default 13: maximum register-list length; legal range 1..13.
REQ-002 Parameter OFFSET_W, default 12: width of the stack-adjust input and the micro-op immediate, two's complement; legal range 8..32.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 in_valid_i  in  1  descriptor valid.
REQ-006 in_ready_o  out  1  sequencer can accept a descriptor.
REQ-007 in_kind_i  in  2  descriptor kind: 00 push, 01 pop, 10 popret, 11 reserved.
REQ-008 in_nregs_i  in  4  number of registers in the list.
REQ-009 in_stack_adj_i  in  OFFSET_W  stack adjustment in bytes, unsigned.
REQ-010 kill_i  in  1  abort the current sequence.
REQ-011 halt_i  in  1  stall the sequencer.
REQ-012 uop_valid_o  out  1  micro-op valid.
REQ-013 uop_ready_i  in  1  micro-op consumed.
REQ-014 uop_op_o  out  2  micro-op type: 00 SW, 01 LW, 10 ADDI_SP, 11 JALR_RA.
REQ-015 uop_reg_o  out  5  data register for SW or LW; 0 for the other types.
REQ-016 uop_imm_o  out  OFFSET_W  signed offset or addend.
REQ-017 uop_first_o / uop_last_o  out  1 each  first / last micro-op of the sequence.
REQ-018 busy_o  out  1  sequence in progress (state is not IDLE).
REQ-019 illegal_o  out  1  registered one-cycle pulse flagging a rejected descriptor.

Function
REQ-020 FSM states SHALL be IDLE, SEQ, FINAL and RET.
REQ-021 in_ready_o SHALL equal (state == IDLE) && !halt_i && !kill_i.
REQ-022 A descriptor is accepted when in_valid_i && in_ready_o.
REQ-023 A descriptor SHALL be illegal when any of the following holds:
- in_kind_i == 11;
- in_nregs_i == 0;
- in_nregs_i > MAX_REGS;
- the kind is pop or popret and in_stack_adj_i < 4*in_nregs_i.
REQ-024 On acceptance of an illegal descriptor: illegal_o = 1 in the next cycle only; the state stays IDLE; no micro-op is issued.
REQ-025 On acceptance of a legal descriptor, the sequencer SHALL:
- latch the kind, n and the stack adjustment;
- clear the index i;
- move to SEQ, so the first micro-op is valid the following cycle (latency 1).
REQ-026 The register map reg(i) SHALL be:
- i = 0 -> x1;
- i = 1 -> x8;
- i = 2 -> x9;
- i = 3..12 -> x(15+i), i.e. x18..x27.
REQ-027 In SEQ, for a push: op = SW, reg = reg(i), imm = -4*(i+1).
REQ-028 In SEQ, for a pop or popret: op = LW, reg = reg(i), imm = stack_adj - 4*(i+1).
REQ-029 In SEQ, each handshake (uop_valid_o && uop_ready_i) SHALL increment i; the handshake with i == n-1 SHALL move the state to FINAL.
REQ-030 In FINAL: op = ADDI_SP, imm = -stack_adj for a push and +stack_adj for a pop or popret.
REQ-031 On the FINAL handshake: popret -> RET; otherwise -> IDLE.
REQ-032 In RET: op = JALR_RA, imm = 0; the handshake SHALL move the state to IDLE.
REQ-033 Micro-op counts: push and pop emit n+1 micro-ops; popret emits n+2.
REQ-034 uop_first_o SHALL be 1 only on the SEQ micro-op with i == 0.
REQ-035 uop_last_o SHALL be 1 on FINAL for push and pop, and on RET for popret.
REQ-036 uop_valid_o SHALL equal (state != IDLE) && !halt_i && !kill_i.
REQ-037 While uop_valid_o && !uop_ready_i, all uop_* fields SHALL hold stable.
REQ-038 halt_i SHALL freeze the state, i and the latched descriptor; no handshake completes while halt_i is high.
REQ-039 kill_i SHALL force the state to IDLE and i to 0 on the next edge. kill_i takes priority over any handshake and over acceptance in the same cycle; a micro-op presented in that cycle is not consumed.
REQ-040 Immediates SHALL be computed modulo 2^OFFSET_W (wrap, no saturation). The index counter SHALL be 4 bits wide.
REQ-041 Back-to-back descriptors: the cycle after the last handshake is IDLE with in_ready_o = 1. The minimum gap between a last micro-op and the next first micro-op is 2 cycles.

Reset
REQ-042 While rst = 1, and on its deassertion:
- state = IDLE and i = 0;
- the latched descriptor is cleared;
- uop_valid_o, uop_first_o, uop_last_o, busy_o and illegal_o are 0;
- uop_op_o, uop_reg_o and uop_imm_o are 0;
- in_ready_o = !halt_i && !kill_i.
REQ-043 Reset asserted mid-sequence SHALL abort the sequence immediately (asynchronously), with no further micro-ops.

Verification
REQ-044 Push, n=3, adj=16, ready held high -> micro-ops, one per cycle starting 1 cycle after acceptance, then IDLE:
- SW x1 -4 (first);
- SW x8 -8;
- SW x9 -12;
- ADDI_SP -16 (last).
REQ-045 Popret, n=13, adj=64 -> 15 micro-ops:
- LW x1 imm 60 first; the 13th is LW x27 imm 12;
- ADDI_SP +64;
- JALR_RA 0 (last).
REQ-046 Pop, n=2, adj=16, with uop_ready_i low 3 cycles on the second micro-op -> LW x8 imm 8 held stable for 4 cycles; total 3 handshakes.
REQ-047 kill_i asserted on the 2nd micro-op of a push with n=4 -> uop_valid_o = 0 that cycle and IDLE the next cycle; a new push, n=1, adj=16, yields SW x1 -4 then ADDI_SP -16.
REQ-048 Illegal cases each pulse illegal_o for 1 cycle with no micro-op:
- kind = 11;
- n = 0;
- n = 14 with MAX_REGS = 13;
- pop with n = 5 and adj = 16.
REQ-049 halt_i high for 2 cycles mid-sequence -> valid low, fields and i frozen; the sequence resumes with an identical micro-op order. rst pulsed mid-sequence -> IDLE, with all outputs at their reset values.

Source files
------------

// File: rtl/cv32e40s_uop_sequencer.sv
// cv32e40s_uop_sequencer
// Expands a push / pop / popret stack descriptor into a stream of micro-ops:
// one SW or LW per listed register, then an ADDI_SP stack adjustment, and for
// popret a final JALR_RA.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   in_valid_i/ready_o descriptor handshake
//   in_kind_i          00 push, 01 pop, 10 popret, 11 reserved
//   in_nregs_i         register-list length
//   in_stack_adj_i     stack adjustment in bytes (unsigned)
//   kill_i             abort the running sequence
//   halt_i             freeze the sequencer
//   uop_valid_o/ready_i micro-op handshake
//   uop_op_o           00 SW, 01 LW, 10 ADDI_SP, 11 JALR_RA
//   uop_reg_o          data register for SW/LW, else 0
//   uop_imm_o          signed offset / addend (wraps modulo 2^OFFSET_W)
//   uop_first_o/last_o first / last micro-op of the sequence
//   busy_o             a sequence is in progress
//   illegal_o          one-cycle pulse after a rejected descriptor
module cv32e40s_uop_sequencer #(
    parameter int MAX_REGS = 13,
    parameter int OFFSET_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [1:0]          in_kind_i,
    input  logic [3:0]          in_nregs_i,
    input  logic [OFFSET_W-1:0] in_stack_adj_i,
    input  logic                kill_i,
    input  logic                halt_i,
    output logic                uop_valid_o,
    input  logic                uop_ready_i,
    output logic [1:0]          uop_op_o,
    output logic [4:0]          uop_reg_o,
    output logic [OFFSET_W-1:0] uop_imm_o,
    output logic                uop_first_o,
    output logic                uop_last_o,
    output logic                busy_o,
    output logic                illegal_o
);

    typedef enum logic [1:0] {IDLE, SEQ, FINAL, RET} state_e;

    localparam logic [1:0] KIND_PUSH   = 2'b00;
    localparam logic [1:0] KIND_POPRET = 2'b10;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    localparam logic [1:0] OP_SW      = 2'b00;
    localparam logic [1:0] OP_LW      = 2'b01;
    localparam logic [1:0] OP_ADDI_SP = 2'b10;
    localparam logic [1:0] OP_JALR_RA = 2'b11;

    localparam logic [3:0] MAX_N = 4'(MAX_REGS);

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [1:0]            kind_q, kind_d;
    logic [3:0]            nregs_q, nregs_d;
    logic [OFFSET_W-1:0]   adj_q, adj_d;
    logic                  illegal_q, illegal_d;

    logic                  accept;
    logic                  handshake;
    logic                  desc_illegal;
    logic [OFFSET_W-1:0]   min_adj;
    logic [3:0]            idx_plus1;
    logic [OFFSET_W-1:0]   step;

    // Handshake qualifiers and descriptor legality.
    // min_adj is 4*n; OFFSET_W >= 8 so the 6-bit product always fits.
    always_comb begin
        in_ready_o   = (state_q == IDLE) && !halt_i && !kill_i;
        uop_valid_o  = (state_q != IDLE) && !halt_i && !kill_i;
        accept       = in_valid_i && in_ready_o;
        handshake    = uop_valid_o && uop_ready_i;
        min_adj      = {{(OFFSET_W-6){1'b0}}, in_nregs_i, 2'b00};
        desc_illegal = (in_kind_i == KIND_RSVD) ||
                       (in_nregs_i == 4'd0) ||
                       (in_nregs_i > MAX_N) ||
                       ((in_kind_i != KIND_PUSH) && (in_stack_adj_i < min_adj));
    end

    // Next-state logic. kill wins over everything; halt needs no explicit
    // branch because it already blocks both acceptance and handshakes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        kind_d    = kind_q;
        nregs_d   = nregs_q;
        adj_d     = adj_q;
        illegal_d = accept && desc_illegal;

        if (kill_i) begin
            state_d = IDLE;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !desc_illegal) begin
                        kind_d  = in_kind_i;
                        nregs_d = in_nregs_i;
                        adj_d   = in_stack_adj_i;
                        idx_d   = 4'd0;
                        state_d = SEQ;
                    end
                end
                SEQ: begin
                    if (handshake) begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == nregs_q - 4'd1) begin
                            state_d = FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (handshake) begin
                        idx_d   = 4'd0;
                        state_d = (kind_q == KIND_POPRET) ? RET : IDLE;
                    end
                end
                RET: begin
                    if (handshake) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Micro-op fields depend only on registered state, so they hold stable
    // while the consumer back-pressures. step is 4*(i+1).
    always_comb begin
        uop_op_o    = 2'b00;
        uop_reg_o   = 5'd0;
        uop_imm_o   = '0;
        uop_first_o = 1'b0;
        uop_last_o  = 1'b0;
        busy_o      = (state_q != IDLE);
        illegal_o   = illegal_q;
        idx_plus1   = idx_q + 4'd1;
        step        = {{(OFFSET_W-6){1'b0}}, idx_plus1, 2'b00};

        case (state_q)
            SEQ: begin
                uop_op_o    = (kind_q == KIND_PUSH) ? OP_SW : OP_LW;
                uop_imm_o   = (kind_q == KIND_PUSH) ? ('0 - step) : (adj_q - step);
                uop_first_o = (idx_q == 4'd0);
                case (idx_q)
                    4'd0:    uop_reg_o = 5'd1;
                    4'd1:    uop_reg_o = 5'd8;
                    4'd2:    uop_reg_o = 5'd9;
                    default: uop_reg_o = {1'b0, idx_q} + 5'd15;
                endcase
            end
            FINAL: begin
                uop_op_o   = OP_ADDI_SP;
                uop_imm_o  = (kind_q == KIND_PUSH) ? ('0 - adj_q) : adj_q;
                uop_last_o = (kind_q != KIND_POPRET);
            end
            RET: begin
                uop_op_o   = OP_JALR_RA;
                uop_last_o = 1'b1;
            end
            default: begin
                uop_op_o = 2'b00;
            end
        endcase
    end

    // State registers; reset clears the latched descriptor as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            kind_q    <= 2'b00;
            nregs_q   <= 4'd0;
            adj_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            kind_q    <= kind_d;
            nregs_q   <= nregs_d;
            adj_q     <= adj_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_cv32e40s_uop_sequencer.sv
// Testbench for cv32e40s_uop_sequencer.
// Descriptors are issued from the main initial block; the expected micro-op
// stream is computed from the push/pop rules and queued. A separate monitor
// compares every presented micro-op against the head of the queue and pops
// it on a handshake; illegal pulses are matched against a pending count.
module tb_cv32e40s_uop_sequencer;

    localparam int MAX_REGS = 13;
    localparam int OFFSET_W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [1:0]          in_kind_i;
    logic [3:0]          in_nregs_i;
    logic [OFFSET_W-1:0] in_stack_adj_i;
    logic                kill_i;
    logic                halt_i;
    logic                uop_valid_o;
    logic                uop_ready_i;
    logic [1:0]          uop_op_o;
    logic [4:0]          uop_reg_o;
    logic [OFFSET_W-1:0] uop_imm_o;
    logic                uop_first_o;
    logic                uop_last_o;
    logic                busy_o;
    logic                illegal_o;

    typedef struct {
        logic [1:0]          op;
        logic [4:0]          rg;
        logic [OFFSET_W-1:0] imm;
        logic                first;
        logic                last;
    } uop_t;

    uop_t exp_q[$];
    uop_t mon_e;
    int   ill_pending = 0;
    int   checks = 0;
    int   errors = 0;

    cv32e40s_uop_sequencer #(.MAX_REGS(MAX_REGS), .OFFSET_W(OFFSET_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_kind_i      (in_kind_i),
        .in_nregs_i     (in_nregs_i),
        .in_stack_adj_i (in_stack_adj_i),
        .kill_i         (kill_i),
        .halt_i         (halt_i),
        .uop_valid_o    (uop_valid_o),
        .uop_ready_i    (uop_ready_i),
        .uop_op_o       (uop_op_o),
        .uop_reg_o      (uop_reg_o),
        .uop_imm_o      (uop_imm_o),
        .uop_first_o    (uop_first_o),
        .uop_last_o     (uop_last_o),
        .busy_o         (busy_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk = ~clk;

    // Reference model: legality and the micro-op list of a descriptor.
    function automatic bit refIllegal(input int kind, input int n, input int adj);
        return (kind == 3) || (n == 0) || (n > MAX_REGS) || ((kind != 0) && (adj < 4 * n));
    endfunction

    function automatic int refReg(input int i);
        int table_r[13] = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};
        return table_r[i];
    endfunction

    task automatic pushExpected(input int kind, input int n, input int adj);
        uop_t u;
        int   val;
        for (int i = 0; i < n; i++) begin
            u.op    = (kind == 0) ? 2'd0 : 2'd1;
            u.rg    = 5'(refReg(i));
            val     = (kind == 0) ? -4 * (i + 1) : adj - 4 * (i + 1);
            u.imm   = val[OFFSET_W-1:0];
            u.first = (i == 0);
            u.last  = 1'b0;
            exp_q.push_back(u);
        end
        u.op    = 2'd2;
        u.rg    = 5'd0;
        val     = (kind == 0) ? -adj : adj;
        u.imm   = val[OFFSET_W-1:0];
        u.first = 1'b0;
        u.last  = (kind != 2);
        exp_q.push_back(u);
        if (kind == 2) begin
            u.op   = 2'd3;
            u.imm  = '0;
            u.last = 1'b1;
            exp_q.push_back(u);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every presented micro-op must match the queue head; it is
    // retired only when the consumer is ready.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (uop_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL uop_unexpected: got op=%0d reg=%0d imm=%0h with nothing expected",
                             uop_op_o, uop_reg_o, uop_imm_o);
                end else begin
                    mon_e = exp_q[0];
                    if (uop_op_o !== mon_e.op || uop_reg_o !== mon_e.rg || uop_imm_o !== mon_e.imm ||
                        uop_first_o !== mon_e.first || uop_last_o !== mon_e.last) begin
                        errors++;
                        $display("[TB] FAIL uop_fields: got op=%0d reg=%0d imm=%0h first=%0b last=%0b, expected op=%0d reg=%0d imm=%0h first=%0b last=%0b",
                                 uop_op_o, uop_reg_o, uop_imm_o, uop_first_o, uop_last_o,
                                 mon_e.op, mon_e.rg, mon_e.imm, mon_e.first, mon_e.last);
                    end
                    if (uop_ready_i) void'(exp_q.pop_front());
                end
            end
            if (illegal_o) begin
                checks++;
                if (ill_pending > 0) begin
                    ill_pending--;
                end else begin
                    errors++;
                    $display("[TB] FAIL illegal_spurious: got illegal_o=1, expected 0");
                end
            end
        end
    end

    // Run cycles until the expected stream is consumed and the DUT is idle.
    // rnd selects randomized back-pressure and halts.
    task automatic drainSequence(input bit rnd);
        int cycles = 0;
        while (exp_q.size() != 0 || busy_o) begin
            if (cycles > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_timeout: got %0d uops outstanding, expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
            if (rnd) begin
                uop_ready_i = ($urandom_range(0, 9) < 7);
                halt_i      = ($urandom_range(0, 9) == 0);
            end else begin
                uop_ready_i = 1'b1;
                halt_i      = 1'b0;
            end
            @(negedge clk);
            if (halt_i) checkOutput("halt_valid", {31'd0, uop_valid_o}, 32'd0);
            @(posedge clk);
            #1;
            cycles++;
        end
        halt_i      = 1'b0;
        uop_ready_i = 1'b1;
        checkOutput("idle_ready", {31'd0, in_ready_o}, 32'd1);
        checkOutput("idle_busy", {31'd0, busy_o}, 32'd0);
    endtask

    // Present one descriptor for one cycle; always called at posedge+1 with
    // the DUT idle.
    task automatic applyStimulus(input int kind, input int n, input int adj, input bit rnd);
        bit ill;
        ill            = refIllegal(kind, n, adj);
        in_valid_i     = 1'b1;
        in_kind_i      = 2'(kind);
        in_nregs_i     = 4'(n);
        in_stack_adj_i = OFFSET_W'(adj);
        halt_i         = 1'b0;
        kill_i         = 1'b0;
        uop_ready_i    = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (ill) ill_pending++;
        else pushExpected(kind, n, adj);
        @(negedge clk);
        checkOutput("accept_ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_i     = 1'b0;
        in_kind_i      = 2'($urandom);
        in_nregs_i     = 4'($urandom);
        in_stack_adj_i = OFFSET_W'($urandom);
        if (ill) begin
            uop_ready_i = 1'b1;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            checkOutput("illegal_pulse", ill_pending, 32'd0);
            checkOutput("illegal_busy", {31'd0, busy_o}, 32'd0);
            ill_pending = 0;
        end else begin
            checkOutput("first_latency", {31'd0, uop_valid_o}, 32'd1);
            checkOutput("first_flag", {31'd0, uop_first_o}, 32'd1);
            drainSequence(rnd);
        end
    endtask

    task automatic issueOnly(input int kind, input int n, input int adj);
        in_valid_i     = 1'b1;
        in_kind_i      = 2'(kind);
        in_nregs_i     = 4'(n);
        in_stack_adj_i = OFFSET_W'(adj);
        uop_ready_i    = 1'b1;
        pushExpected(kind, n, adj);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        in_valid_i     = 1'b0;
        in_kind_i      = 2'd0;
        in_nregs_i     = 4'd0;
        in_stack_adj_i = '0;
        kill_i         = 1'b0;
        halt_i         = 1'b0;
        uop_ready_i    = 1'b0;

        // Reset values
        @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'd0, uop_valid_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal_o}, 32'd0);
        checkOutput("rst_fields", {uop_op_o, uop_reg_o, uop_imm_o, uop_first_o, uop_last_o}, 32'd0);
        checkOutput("rst_ready", {31'd0, in_ready_o}, 32'd1);
        halt_i = 1'b1;
        #1;
        checkOutput("rst_ready_halt", {31'd0, in_ready_o}, 32'd0);
        halt_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed sequences
        applyStimulus(0, 3, 16, 1'b0);
        applyStimulus(2, 13, 64, 1'b0);

        // Back-pressure on the second micro-op of a pop
        issueOnly(1, 2, 16);
        @(posedge clk);
        #1;
        uop_ready_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        uop_ready_i = 1'b1;
        drainSequence(1'b0);

        // Kill on the second micro-op of a push
        issueOnly(0, 4, 16);
        @(posedge clk);
        #1;
        kill_i = 1'b1;
        @(negedge clk);
        checkOutput("kill_valid", {31'd0, uop_valid_o}, 32'd0);
        checkOutput("kill_in_ready", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        exp_q.delete();
        checkOutput("kill_idle", {31'd0, busy_o}, 32'd0);
        applyStimulus(0, 1, 16, 1'b0);

        // Illegal descriptors
        applyStimulus(3, 2, 16, 1'b0);
        applyStimulus(0, 0, 16, 1'b0);
        applyStimulus(0, 14, 16, 1'b0);
        applyStimulus(1, 5, 16, 1'b0);

        // Halt for two cycles mid-sequence
        issueOnly(0, 5, 40);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        halt_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("halt_frozen_valid", {31'd0, uop_valid_o}, 32'd0);
            if (exp_q.size() > 0) begin
                checkOutput("halt_frozen_reg", {27'd0, uop_reg_o}, {27'd0, exp_q[0].rg});
                checkOutput("halt_frozen_imm", {20'd0, uop_imm_o}, {20'd0, exp_q[0].imm});
            end
            @(posedge clk);
            #1;
        end
        halt_i = 1'b0;
        drainSequence(1'b0);

        // Reset pulsed mid-sequence
        issueOnly(2, 13, 64);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("midrst_valid", {31'd0, uop_valid_o}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("midrst_fields", {uop_op_o, uop_reg_o, uop_imm_o, uop_first_o, uop_last_o}, 32'd0);
        checkOutput("midrst_ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_valid", {31'd0, uop_valid_o}, 32'd0);
        checkOutput("postrst_illegal", {31'd0, illegal_o}, 32'd0);
        @(posedge clk);
        #1;

        // Randomized descriptors with random back-pressure and halts
        for (int k = 0; k < 60; k++) begin
            int kind, n, adj;
            kind = $urandom_range(0, 3);
            n    = $urandom_range(0, 15);
            adj  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 80);
            applyStimulus(kind, n, adj, 1'b1);
        end

        checkOutput("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
